// File: rtl/dqsw_tap_trainer_if.sv
// Bundle of the trainer's handshake and delay-line signals between the DDR
// training controller / IOD (master) and the DQSW tap trainer (slave).
interface dqsw_tap_trainer_if #(
    parameter int unsigned TAP_W = 8
);
    logic             START;
    logic             BUSY;
    logic             DONE;
    logic [1:0]       ERR_CODE;
    logic [TAP_W-1:0] EDGE_TAP;
    logic             PULSE_REQ;
    logic             PULSE_ACK;
    logic [1:0]       SAMPLE_DATA;
    logic             DELAY_LINE_LOAD;
    logic             DELAY_LINE_MOVE;
    logic             DELAY_LINE_DIRECTION;
    logic             DELAY_LINE_OUT_OF_RANGE;
    logic             EYE_MONITOR_CLEAR_FLAGS;

    // Training controller / IOD side
    modport master (
        output START, PULSE_ACK, SAMPLE_DATA, DELAY_LINE_OUT_OF_RANGE,
        input  BUSY, DONE, ERR_CODE, EDGE_TAP, PULSE_REQ,
               DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
               EYE_MONITOR_CLEAR_FLAGS
    );

    // Tap trainer side
    modport slave (
        input  START, PULSE_ACK, SAMPLE_DATA, DELAY_LINE_OUT_OF_RANGE,
        output BUSY, DONE, ERR_CODE, EDGE_TAP, PULSE_REQ,
               DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
               EYE_MONITOR_CLEAR_FLAGS
    );
endinterface

// File: rtl/dqsw_tap_trainer.sv
// DQSW write-leveling tap trainer: sweeps the output delay line upward,
// samples write-leveling feedback at every tap, finds the first low->high
// transition, optionally backs off a few taps and reports the result.
module dqsw_tap_trainer #(
    parameter int unsigned TAP_W         = 8,
    parameter int unsigned MAX_TAPS      = 127,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLES       = 4,
    parameter int unsigned BACKOFF       = 0
) (
    input logic               FAB_CLK,
    input logic               ARST_N,
    dqsw_tap_trainer_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL,
        S_MOVE, S_BACKOFF, S_DONE, S_FAIL
    } state_t;

    localparam logic [TAP_W-1:0] MAX_TAP_T   = TAP_W'(MAX_TAPS);
    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0]      SAMPLES_T   = 16'(SAMPLES);

    state_t           r_state;
    logic [TAP_W-1:0] r_tap;
    logic [TAP_W-1:0] r_nback;
    logic [TAP_W-1:0] r_edge;
    logic [15:0]      r_settle_cnt;
    logic [15:0]      r_sample_cnt;
    logic             r_hi;
    logic             r_seen_low;
    logic             r_backing;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_err;
    logic             r_req;
    logic             r_load;
    logic             r_move;
    logic             r_dir;
    logic             r_clear;

    logic [TAP_W-1:0] w_nback;
    logic             w_oor_fail;

    // Backoff saturates at tap 0
    assign w_nback    = (BACKOFF < 32'(r_tap)) ? TAP_W'(BACKOFF) : r_tap;
    assign w_oor_fail = bus.DELAY_LINE_OUT_OF_RANGE &&
                        (r_state inside {S_SETTLE, S_SAMPLE, S_EVAL, S_MOVE, S_BACKOFF});

    // Training sequencer with registered outputs
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_state      <= S_IDLE;
            r_tap        <= '0;
            r_nback      <= '0;
            r_edge       <= '0;
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_hi         <= 1'b0;
            r_seen_low   <= 1'b0;
            r_backing    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 2'b00;
            r_req        <= 1'b0;
            r_load       <= 1'b0;
            r_move       <= 1'b0;
            r_dir        <= 1'b0;
            r_clear      <= 1'b0;
        end else begin
            r_load  <= 1'b0;
            r_clear <= 1'b0;
            r_move  <= 1'b0;
            if (w_oor_fail) begin
                r_state <= S_FAIL;
                r_err   <= 2'b01;
                r_busy  <= 1'b0;
                r_req   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE, S_FAIL: begin
                        if (bus.START) begin
                            // Load-cycle initialisation is applied on entry so
                            // it is already visible during the LOAD pulse
                            r_state    <= S_LOAD;
                            r_load     <= 1'b1;
                            r_clear    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_err      <= 2'b00;
                            r_edge     <= '0;
                            r_tap      <= '0;
                            r_seen_low <= 1'b0;
                            r_backing  <= 1'b0;
                            r_nback    <= '0;
                            r_dir      <= 1'b1;
                        end
                    end
                    S_LOAD, S_MOVE: begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= '0;
                    end
                    S_SETTLE: begin
                        if (r_settle_cnt == SETTLE_LAST) begin
                            if (!r_backing) begin
                                r_state      <= S_SAMPLE;
                                r_req        <= 1'b1;
                                r_sample_cnt <= '0;
                                r_hi         <= 1'b1;
                            end else if (r_nback != '0) begin
                                r_state <= S_BACKOFF;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_edge  <= r_tap;
                            end
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 16'd1;
                        end
                    end
                    S_SAMPLE: begin
                        // Request is dropped for one cycle after every ACK,
                        // including the last one before EVAL
                        if (r_req) begin
                            if (bus.PULSE_ACK) begin
                                r_req        <= 1'b0;
                                r_hi         <= r_hi & (bus.SAMPLE_DATA == 2'b11);
                                r_sample_cnt <= r_sample_cnt + 16'd1;
                            end
                        end else if (r_sample_cnt == SAMPLES_T) begin
                            r_state <= S_EVAL;
                        end else begin
                            r_req <= 1'b1;
                        end
                    end
                    S_EVAL: begin
                        if (r_hi && r_seen_low) begin
                            if (w_nback != '0) begin
                                r_state   <= S_BACKOFF;
                                r_backing <= 1'b1;
                                r_nback   <= w_nback;
                                r_dir     <= 1'b0;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_edge  <= r_tap;
                            end
                        end else begin
                            if (!r_hi) begin
                                r_seen_low <= 1'b1;
                            end
                            if (r_tap == MAX_TAP_T) begin
                                r_state <= S_FAIL;
                                r_err   <= 2'b10;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_MOVE;
                                r_move  <= 1'b1;
                                r_tap   <= r_tap + TAP_W'(1);
                            end
                        end
                    end
                    S_BACKOFF: begin
                        r_state <= S_MOVE;
                        r_move  <= 1'b1;
                        r_tap   <= r_tap - TAP_W'(1);
                        r_nback <= r_nback - TAP_W'(1);
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.BUSY                    = r_busy;
    assign bus.DONE                    = r_done;
    assign bus.ERR_CODE                = r_err;
    assign bus.EDGE_TAP                = r_edge;
    assign bus.PULSE_REQ               = r_req;
    assign bus.DELAY_LINE_LOAD         = r_load;
    assign bus.DELAY_LINE_MOVE         = r_move;
    assign bus.DELAY_LINE_DIRECTION    = r_dir;
    assign bus.EYE_MONITOR_CLEAR_FLAGS = r_clear;
endmodule

// File: tb/tb_dqsw_tap_trainer.sv
// Bench for the DQSW tap trainer: drives per-tap feedback profiles through a
// responder and compares outcomes with a tap-scan reference model.
module tb_dqsw_tap_trainer;
    localparam int unsigned TW = 8;
    localparam int unsigned MT = 15;
    localparam int unsigned ST = 8;
    localparam int unsigned SM = 4;
    localparam int unsigned BK = 2;
    localparam int          BUDGET = 6000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [1:0] prof [0:MT][0:SM-1];

    always #5 clk = ~clk;

    dqsw_tap_trainer_if #(.TAP_W(TW)) u_if ();

    dqsw_tap_trainer #(
        .TAP_W(TW), .MAX_TAPS(MT), .SETTLE_CYCLES(ST), .SAMPLES(SM), .BACKOFF(BK)
    ) u_dut (
        .FAB_CLK(clk),
        .ARST_N (rst_n),
        .bus    (u_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"},  32'(u_if.BUSY), 0);
        check({tag, ".done"},  32'(u_if.DONE), 0);
        check({tag, ".err"},   32'(u_if.ERR_CODE), 0);
        check({tag, ".edge"},  32'(u_if.EDGE_TAP), 0);
        check({tag, ".req"},   32'(u_if.PULSE_REQ), 0);
        check({tag, ".load"},  32'(u_if.DELAY_LINE_LOAD), 0);
        check({tag, ".move"},  32'(u_if.DELAY_LINE_MOVE), 0);
        check({tag, ".dir"},   32'(u_if.DELAY_LINE_DIRECTION), 0);
        check({tag, ".clear"}, 32'(u_if.EYE_MONITOR_CLEAR_FLAGS), 0);
    endtask

    // Taps below edge return low_val on every sample, taps from edge on return 11
    task automatic fill_step(input int edge_at, input logic [1:0] low_val);
        for (int t = 0; t <= int'(MT); t++)
            for (int s = 0; s < int'(SM); s++)
                prof[t][s] = (t >= edge_at) ? 2'b11 : low_val;
    endtask

    // Reference: walk the taps in order and apply the training rules directly
    task automatic model(input int oor_tap, output int e_done, output int e_err,
                         output int e_edge, output int e_up, output int e_down);
        bit seen;
        bit hi;
        int nb;
        seen = 0;
        e_done = 0; e_err = 0; e_edge = 0; e_up = 0; e_down = 0;
        for (int t = 0; t <= int'(MT); t++) begin
            if (t == oor_tap) begin
                e_err = 1;
                e_up  = t;
                return;
            end
            hi = 1;
            for (int s = 0; s < int'(SM); s++)
                if (prof[t][s] != 2'b11) hi = 0;
            if (hi && seen) begin
                nb = (int'(BK) < t) ? int'(BK) : t;
                e_done = 1; e_edge = t - nb; e_up = t; e_down = nb;
                return;
            end
            if (!hi) seen = 1;
        end
        e_err = 2;
        e_up  = int'(MT);
    endtask

    task automatic run(input string tag, input int ack_dly, input int oor_tap, input bit noise);
        int e_done, e_err, e_edge, e_up, e_down;
        int n, tap_m, sidx, wait_c, ups, downs, loads, dir_viol, gap_min, up_gap;
        int last_move_n, since_move, first_req, oor_n, extra;
        bit prev_dir, last_up;
        model(oor_tap, e_done, e_err, e_edge, e_up, e_down);
        @(negedge clk); u_if.START = 1'b1;
        @(negedge clk); u_if.START = 1'b0;
        n = 1;
        check({tag, ".load"},    32'(u_if.DELAY_LINE_LOAD), 1);
        check({tag, ".clear"},   32'(u_if.EYE_MONITOR_CLEAR_FLAGS), 1);
        check({tag, ".busy"},    32'(u_if.BUSY), 1);
        check({tag, ".cleared"}, 32'({u_if.DONE, u_if.ERR_CODE, u_if.EDGE_TAP}), 0);
        tap_m = 0; sidx = 0; wait_c = 0; ups = 0; downs = 0; loads = 1; dir_viol = 0;
        gap_min = 1000000; up_gap = -1; last_move_n = -1; since_move = 0;
        first_req = -1; oor_n = -1; extra = 0; last_up = 0;
        prev_dir = u_if.DELAY_LINE_DIRECTION;
        while (n < BUDGET) begin
            @(negedge clk);
            n++;
            since_move++;
            if (u_if.DELAY_LINE_LOAD) loads++;
            if (u_if.PULSE_REQ && first_req < 0) first_req = n;
            if (u_if.DELAY_LINE_MOVE) begin
                if (u_if.DELAY_LINE_DIRECTION !== prev_dir) dir_viol++;
                if (last_move_n >= 0 && n - last_move_n < gap_min) gap_min = n - last_move_n;
                if (u_if.DELAY_LINE_DIRECTION) begin
                    if (last_up && last_move_n >= 0) up_gap = n - last_move_n;
                    ups++; tap_m++; last_up = 1;
                end else begin
                    downs++; tap_m--; last_up = 0;
                end
                last_move_n = n; since_move = 0; sidx = 0; wait_c = 0;
            end
            prev_dir = u_if.DELAY_LINE_DIRECTION;
            if (oor_n >= 0 && n == oor_n + 1) begin
                check({tag, ".oor_err"},  32'(u_if.ERR_CODE), 1);
                check({tag, ".oor_busy"}, 32'(u_if.BUSY), 0);
            end
            if (!u_if.BUSY) break;
            u_if.START = noise && (n == 40);
            u_if.DELAY_LINE_OUT_OF_RANGE = 1'b0;
            u_if.PULSE_ACK = 1'b0;
            u_if.SAMPLE_DATA = 2'($urandom_range(0, 3));
            if (u_if.PULSE_REQ) begin
                if (wait_c >= ack_dly) begin
                    u_if.PULSE_ACK = 1'b1;
                    if (tap_m >= 0 && tap_m <= int'(MT))
                        u_if.SAMPLE_DATA = prof[tap_m][sidx % int'(SM)];
                    sidx++;
                    wait_c = 0;
                end else begin
                    wait_c++;
                end
            end else if (noise && $urandom_range(0, 2) == 0) begin
                u_if.PULSE_ACK = 1'b1;
                u_if.SAMPLE_DATA = 2'b00;
            end
            if (oor_tap > 0 && last_up && tap_m == oor_tap && since_move == 2) begin
                u_if.DELAY_LINE_OUT_OF_RANGE = 1'b1;
                oor_n = n;
            end
        end
        u_if.START = 1'b0;
        u_if.PULSE_ACK = 1'b0;
        u_if.DELAY_LINE_OUT_OF_RANGE = 1'b0;
        check({tag, ".timeout"},   32'(n < BUDGET), 1);
        check({tag, ".done"},      32'(u_if.DONE), 32'(e_done));
        check({tag, ".err"},       32'(u_if.ERR_CODE), 32'(e_err));
        check({tag, ".edge_tap"},  32'(u_if.EDGE_TAP), 32'(e_edge));
        check({tag, ".up_moves"},  32'(ups), 32'(e_up));
        check({tag, ".dn_moves"},  32'(downs), 32'(e_down));
        check({tag, ".loads"},     32'(loads), 1);
        check({tag, ".dir_stable"}, 32'(dir_viol), 0);
        check({tag, ".move_gap"},  32'(gap_min >= int'(ST) + 1), 1);
        check({tag, ".first_req"}, 32'(first_req), ST + 2);
        if (ack_dly == 0 && up_gap >= 0)
            check({tag, ".tap_period"}, 32'(up_gap), ST + 2 * SM + 2);
        if (e_err == 1)
            check({tag, ".oor_hit"}, 32'(oor_n >= 0), 1);
        repeat (20) begin
            @(negedge clk);
            if (u_if.DELAY_LINE_LOAD || u_if.DELAY_LINE_MOVE || u_if.PULSE_REQ) extra++;
        end
        check({tag, ".quiet_after"}, 32'(extra), 0);
        check({tag, ".done_hold"},   32'(u_if.DONE), 32'(e_done));
    endtask

    initial begin
        int k;
        int oor;
        int cnt;
        n_tests = 0;
        n_fail  = 0;
        u_if.START = 1'b0;
        u_if.PULSE_ACK = 1'b0;
        u_if.SAMPLE_DATA = 2'b00;
        u_if.DELAY_LINE_OUT_OF_RANGE = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        fill_step(5, 2'b00);
        run("edge5", 0, -1, 0);

        fill_step(int'(MT) + 1, 2'b00);
        run("no_edge", 0, -1, 0);

        fill_step(int'(MT) + 1, 2'b00);
        run("oor3", 0, 3, 0);

        fill_step(3, 2'b00);
        prof[2][0] = 2'b11; prof[2][1] = 2'b11; prof[2][2] = 2'b01; prof[2][3] = 2'b11;
        run("mixed_slow_ack", 5, -1, 0);

        fill_step(1, 2'b00);
        run("edge1", 1, -1, 1);

        // Reset while a pulse request is outstanding
        fill_step(int'(MT) + 1, 2'b00);
        @(negedge clk); u_if.START = 1'b1;
        @(negedge clk); u_if.START = 1'b0;
        repeat (30) @(negedge clk);
        check("rst.req_held", 32'(u_if.PULSE_REQ), 1);
        check("rst.busy",     32'(u_if.BUSY), 1);
        #2 rst_n = 1'b0;
        #1 check_idle("rst.async");
        @(negedge clk) rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (u_if.DELAY_LINE_LOAD || u_if.BUSY) cnt++;
        end
        check("rst.no_resume", 32'(cnt), 0);
        fill_step(4, 2'b01);
        run("after_rst", 0, -1, 0);

        for (int r = 0; r < 12; r++) begin
            k = int'($urandom_range(0, MT + 2));
            for (int t = 0; t <= int'(MT); t++)
                for (int s = 0; s < int'(SM); s++)
                    prof[t][s] = (t >= k) ? 2'b11 : 2'($urandom_range(0, 3));
            oor = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MT)) : -1;
            run($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), oor, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
